// File: rtl/l2_request_arbiter_pkg.sv
// Shared types and sizing for the L2 request arbiter and its neighbours.
// Holds the request packet layout, default core count and FIFO depth,
// and a helper that sizes requester index fields (never narrower than 1 bit).
package l2_request_arbiter_pkg;

  localparam int NUM_CORES         = 4;
  localparam int L2_ARB_FIFO_DEPTH = 4;

  // Index width for N requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int L2_REQ_IDX_W = idx_width(NUM_CORES);

  typedef logic [L2_REQ_IDX_W-1:0] l2_requester_idx_t;

  typedef enum logic [2:0] {
    L2REQ_LOAD       = 3'd0,
    L2REQ_STORE      = 3'd1,
    L2REQ_WRITEBACK  = 3'd2,
    L2REQ_FLUSH      = 3'd3,
    L2REQ_LOAD_SYNC  = 3'd4,
    L2REQ_STORE_SYNC = 3'd5,
    L2REQ_IINVALIDATE = 3'd6,
    L2REQ_DINVALIDATE = 3'd7
  } l2req_type_t;

  typedef struct packed {
    l2req_type_t packet_type;
    logic [3:0]  id;
    logic [25:0] address;
    logic [3:0]  store_mask;
    logic [31:0] data;
  } l2req_packet_t;

endpackage

// File: rtl/l2_request_arbiter_if.sv
// Bundle of core request ports, restart port and the selected-request output.
// master = request sources plus downstream pipeline; slave = the arbiter.
// l2_ready is per core and depends only on arbiter-internal registers.
interface l2_request_arbiter_if
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES
) ();
  localparam int IDX_W = idx_width(NUM_REQUESTERS);

  logic [NUM_REQUESTERS-1:0] l2i_request_valid;
  l2req_packet_t             l2i_request [NUM_REQUESTERS];
  logic [NUM_REQUESTERS-1:0] l2_ready;
  logic                      restart_valid;
  l2req_packet_t             restart_request;
  logic                      pipe_stall;
  logic                      arb_request_valid;
  l2req_packet_t             arb_request;
  logic                      arb_is_restart;
  logic [IDX_W-1:0]          arb_requester;

  modport master (
    output l2i_request_valid, l2i_request, restart_valid, restart_request, pipe_stall,
    input  l2_ready, arb_request_valid, arb_request, arb_is_restart, arb_requester
  );

  modport slave (
    input  l2i_request_valid, l2i_request, restart_valid, restart_request, pipe_stall,
    output l2_ready, arb_request_valid, arb_request, arb_is_restart, arb_requester
  );
endinterface

// File: rtl/l2_request_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after the pointer.
// Latency: combinational grant; the pointer moves on the edge an update is enabled.
// Backpressure: pointer holds whenever i_update_lru is low or nothing requests.
module rr_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_REQUESTERS-1:0]             i_request,
  input  logic                                  i_update_lru,
  output logic [NUM_REQUESTERS-1:0]             o_grant,
  output logic [idx_width(NUM_REQUESTERS)-1:0]  o_grant_idx
);
  localparam int N  = NUM_REQUESTERS;
  localparam int IW = idx_width(NUM_REQUESTERS);
  localparam logic [N-1:0]  REQ_ONE = 1;
  localparam logic [IW-1:0] PTR_ONE = 1;
  localparam logic [IW-1:0] PTR_MAX = IW'(N - 1);

  logic [IW-1:0]  r_ptr;
  logic [2*N-1:0] w_req_dbl;
  logic [2*N-1:0] w_gnt_dbl;
  logic [N-1:0]   w_req_rot;
  logic [N-1:0]   w_gnt_rot;

  // Rotate so the pointer position sits at bit 0, isolate the lowest set bit,
  // then rotate the one-hot result back into requester order.
  assign w_req_dbl = {i_request, i_request} >> r_ptr;
  assign w_req_rot = w_req_dbl[N-1:0];
  assign w_gnt_rot = w_req_rot & (~w_req_rot + REQ_ONE);
  assign w_gnt_dbl = {w_gnt_rot, w_gnt_rot} << r_ptr;
  assign o_grant   = w_gnt_dbl[2*N-1:N];

  // Encode the one-hot grant into a requester index.
  always_comb begin
    o_grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (o_grant[i]) o_grant_idx = IW'(i);
    end
  end

  // Pointer moves just past the winner so the winner becomes lowest priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_update_lru && (|i_request)) begin
      r_ptr <= (o_grant_idx == PTR_MAX) ? '0 : o_grant_idx + PTR_ONE;
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, DEPTH a power of two.
// Latency: a pushed entry is visible at o_dat the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty; o_full is registered.
module sync_fifo #(
  parameter type data_t = logic,
  parameter int  DEPTH  = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_push,
  input  data_t i_dat,
  input  logic  i_pop,
  output data_t o_dat,
  output logic  o_empty,
  output logic  o_full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH;

  data_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_MAX);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dat   = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; push+pop together leaves the count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat;
  end

endmodule

// File: rtl/l2_request_arbiter.sv
// L2 input stage: per-core request FIFOs, restart-first then round-robin selection.
// Latency: 2 cycles from accepted request to registered arb_request_valid.
// Backpressure: l2_ready per core from FIFO fullness; pipe_stall freezes output, pops and pointer.
module l2_request_arbiter
  import l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES,
  parameter int FIFO_DEPTH     = L2_ARB_FIFO_DEPTH
) (
  input logic                 clk,
  input logic                 reset,
  l2_request_arbiter_if.slave arb_if
);
  localparam int N  = NUM_REQUESTERS;
  localparam int IW = idx_width(NUM_REQUESTERS);

  logic [N-1:0]  w_push;
  logic [N-1:0]  w_pop;
  logic [N-1:0]  w_empty;
  logic [N-1:0]  w_full;
  logic [N-1:0]  w_nonempty;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_grant_idx;
  l2req_packet_t w_head [N];
  l2req_packet_t w_sel_pkt;
  logic          w_advance;
  logic          w_core_sel;

  logic          r_arb_vld;
  l2req_packet_t r_arb_pkt;
  logic          r_arb_is_restart;
  logic [IW-1:0] r_arb_requester;

  // A restart pre-empts every core; cores only win when the pipe advances.
  assign w_advance  = ~arb_if.pipe_stall;
  assign w_nonempty = ~w_empty;
  assign w_core_sel = w_advance & ~arb_if.restart_valid & (|w_nonempty);
  assign w_pop      = w_grant & {N{w_core_sel}};

  // Ready comes straight from registered FIFO occupancy.
  assign arb_if.l2_ready = ~w_full;

  for (genvar g = 0; g < N; g++) begin : g_core
    assign w_push[g] = arb_if.l2i_request_valid[g] & ~w_full[g];

    sync_fifo #(
      .data_t (l2req_packet_t),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push[g]),
      .i_dat   (arb_if.l2i_request[g]),
      .i_pop   (w_pop[g]),
      .o_dat   (w_head[g]),
      .o_empty (w_empty[g]),
      .o_full  (w_full[g])
    );
  end

  rr_arbiter #(
    .NUM_REQUESTERS (N)
  ) u_rr (
    .clk          (clk),
    .reset        (reset),
    .i_request    (w_nonempty),
    .i_update_lru (w_core_sel),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  // Head packet of the granted FIFO.
  always_comb begin
    w_sel_pkt = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) w_sel_pkt = w_head[i];
    end
  end

  // Output register: holds under stall, restart first, else round-robin winner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_arb_vld        <= 1'b0;
      r_arb_pkt        <= '0;
      r_arb_is_restart <= 1'b0;
      r_arb_requester  <= '0;
    end else if (w_advance) begin
      if (arb_if.restart_valid) begin
        r_arb_vld        <= 1'b1;
        r_arb_pkt        <= arb_if.restart_request;
        r_arb_is_restart <= 1'b1;
        r_arb_requester  <= '0;
      end else if (w_core_sel) begin
        r_arb_vld        <= 1'b1;
        r_arb_pkt        <= w_sel_pkt;
        r_arb_is_restart <= 1'b0;
        r_arb_requester  <= w_grant_idx;
      end else begin
        r_arb_vld        <= 1'b0;
        r_arb_is_restart <= 1'b0;
        r_arb_requester  <= '0;
      end
    end
  end

  assign arb_if.arb_request_valid = r_arb_vld;
  assign arb_if.arb_request       = r_arb_pkt;
  assign arb_if.arb_is_restart    = r_arb_is_restart;
  assign arb_if.arb_requester     = r_arb_requester;

endmodule

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
- Input stage of the L2 cache, directly upstream of the L2 tag/read/update pipeline.
- Buffers L2 requests from each core in a per-core FIFO and selects one request per cycle for the pipeline.
- A returning miss fill (restart) has absolute priority. Otherwise cores are served round-robin.
- Per-core request order is preserved. Sync load/store reservation semantics depend on this ordering.

Parameters:
NUM_REQUESTERS, `NUM_CORES, number of core request ports
FIFO_DEPTH, 4, entries per core request FIFO (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  reset
l2i_request_valid  in  NUM_REQUESTERS  per-core request valid
l2i_request  in  l2req_packet_t[NUM_REQUESTERS]  per-core request packet
l2_ready  out  NUM_REQUESTERS  per-core FIFO can accept
restart_valid  in  1  fill-complete request re-entering the pipeline
restart_request  in  l2req_packet_t  restarted packet
pipe_stall  in  1  downstream pipeline cannot advance
arb_request_valid  out  1  registered output valid
arb_request  out  l2req_packet_t  registered selected packet
arb_is_restart  out  1  selected packet came from the restart port
arb_requester  out  $clog2(NUM_REQUESTERS) (min 1)  source core index; 0 for restart

Behaviour:
- Reset: asynchronous, active-high; clock clk.
  - Reset empties all FIFOs and sets the RR pointer to 0.
  - arb_request_valid=0, arb_is_restart=0, arb_requester=0, arb_request='0. l2_ready goes to all 1s after reset.
  - Reset asserted mid-operation discards all buffered and in-flight requests. No output appears after reset deasserts until new input arrives.
- Handshake:
  - l2_ready[i] = (count[i] != FIFO_DEPTH). It is decoded from registers only, with no combinational path from any input.
  - A push occurs on a posedge when l2i_request_valid[i] && l2_ready[i]. The requester holds valid and packet until accepted.
  - A valid presented while ready=0 is ignored and never written.
- Selection (evaluated when pipe_stall=0):
  - Priority 1: restart_valid → output restart_request with arb_is_restart=1 and arb_requester=0. No FIFO pops; the RR pointer is unchanged.
  - Priority 2: otherwise scan non-empty FIFOs starting at rr_ptr, wrapping modulo NUM_REQUESTERS. The winner w is popped, output with arb_requester=w, and rr_ptr becomes (w+1) mod NUM_REQUESTERS.
  - If nothing is eligible, arb_request_valid=0 next cycle.
- Stall:
  - While pipe_stall=1 the output registers hold, there are no pops, and rr_ptr holds.
  - restart_valid must stay asserted by its source until the cycle it is selected. restart is never dropped.
- Eligibility: only entries present at the start of the cycle participate. A push and the selection of that same entry never occur in one cycle.
- Latency: request accepted at edge N → earliest arb_request_valid in the cycle after edge N+1, i.e. 2 cycles from valid to output.
- Simultaneous push and pop on one FIFO: count is unchanged and FIFO order is preserved.
- Full FIFO with a pop in the same cycle: ready was already 0, so there is no push. ready rises in the following cycle.
- Starvation: at most NUM_REQUESTERS-1 other-core grants occur between grants to a non-empty FIFO, excluding restart cycles.
- Packets pass through bit-exact, including store_mask, data, id and packet_type. There is no decoding of packet_type.

Decomposition:
- Shared package (defines): l2req_packet_t (existing), plus L2_ARB_FIFO_DEPTH localparam and the requester index width type.
- Sub-module: rr_arbiter (NUM_REQUESTERS-wide request vector, update_lru enable, one-hot grant).
- FIFOs are instantiated from the existing synchronous FIFO, one per core.

Test Plan:
- Single LOAD, core 0, address 'h123 in cycle 0 → arb_request_valid in cycle 2 with address 'h123, arb_requester=0, arb_is_restart=0; valid low in cycle 3.
- Core 0 issues LOAD_SYNC id1, LOAD_SYNC id2, STORE_SYNC id1 (data 'h43931f6f), STORE_SYNC id2 (data 'h44dff947) back-to-back → output order is id1 LOAD_SYNC, id2 LOAD_SYNC, id1 STORE_SYNC, id2 STORE_SYNC with data unchanged.
- Cores 0,1,2,3 each hold 2 entries, no stall → grant sequence 0,1,2,3,0,1,2,3; rr_ptr wraps from 3 to 0.
- restart_valid together with cores 1 and 2 pending, rr_ptr=1 → restart first (arb_is_restart=1), then 1, then 2. rr_ptr is unchanged by the restart grant.
- pipe_stall=1 for 5 cycles with 5 core-0 pushes attempted → output held; l2_ready[0] falls after 4 accepts; 5th request is accepted only after the stall releases; no loss or duplication.
- reset asserted with 3 entries buffered and output valid → arb_request_valid=0 immediately; after deassert no output until a new request arrives.
